// File: rtl/btn_capture.sv
// btn_capture: debounced pushbutton capture for the PL-to-PS input path.
//
// Each raw button passes through a 2-flop synchronizer and a per-bit debounce
// counter. A debounced rising level (a press) sets a sticky event flag. The PS
// clears that flag on the rising edge of the matching clr bit. A level
// interrupt, a wrapping press counter and the index of the last pressed
// button are also kept.
//
// Ports:
//   clk        in   single clock domain (pl_clk0)
//   rst_n      in   asynchronous active-low reset (pl_resetn0)
//   btn_in     in   raw buttons, active-high, asynchronous to clk
//   clr        in   per-button event clear, acts on its rising edge
//   btn_state  out  debounced button level
//   btn_event  out  sticky press flags
//   press_cnt  out  total presses across all buttons, modulo 256
//   last_btn   out  index of the most recently pressed button
//   irq        out  registered OR of btn_event
module btn_capture #(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned NUM_BTN     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [NUM_BTN-1:0] clr,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] btn_event,
    output logic [7:0]         press_cnt,
    output logic [2:0]         last_btn,
    output logic               irq
);

    localparam int unsigned DB_TICKS = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam logic [31:0] DB_LAST  = 32'(DB_TICKS - 1);

    // Synchronizer stages; sync2_q is the synchronized button level.
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;

    logic [NUM_BTN-1:0] state_q,  state_d;
    logic [31:0]        db_cnt_q [NUM_BTN];
    logic [31:0]        db_cnt_d [NUM_BTN];

    logic [NUM_BTN-1:0] clr_q;
    logic [NUM_BTN-1:0] event_q,  event_d;
    logic [7:0]         cnt_q,    cnt_d;
    logic [2:0]         last_q,   last_d;
    logic               irq_q;

    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] clr_edge;
    logic [7:0]         press_add;

    // Debounce: any cycle of agreement restarts the window; after DB_TICKS
    // consecutive cycles of disagreement the debounced level follows.
    always_comb begin
        state_d = state_q;
        press   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == state_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                state_d[i]  = sync2_q[i];
                db_cnt_d[i] = '0;
                // Disagreement with a new level of 1 means a 0->1 commit.
                press[i]    = sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 32'd1;
            end
        end
    end

    // Event flags, press counter and last index.
    always_comb begin
        clr_edge  = clr & ~clr_q;
        // Set has priority over a clear arriving on the same edge.
        event_d   = (event_q & ~clr_edge) | press;
        press_add = '0;
        last_d    = last_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            press_add = press_add + 8'(press[i]);
        end
        // Walk downwards so the lowest pressed index is the one that sticks.
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press[i]) begin
                last_d = 3'(i);
            end
        end
        cnt_d = cnt_q + press_add;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= '0;
            end
            clr_q   <= '0;
            event_q <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            clr_q   <= clr;
            event_q <= event_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            irq_q   <= |event_q;
        end
    end

    assign btn_state = state_q;
    assign btn_event = event_q;
    assign press_cnt = cnt_q;
    assign last_btn  = last_q;
    assign irq       = irq_q;

endmodule
